// File: rtl/fpaddsub_pipe.sv
// rtl/fpaddsub_pipe.sv - three-stage pipelined floating-point add/sub with RNE rounding,
// special-value handling, exception flags and global-stall valid/ready flow control.
module fpaddsub_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic                   op_sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic                   overflow,
   output logic                   underflow,
   output logic                   invalid
);
   localparam int W = 1 + EXP_W + MAN_W;
   localparam int M = MAN_W + 4;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // ---------------- stage 1: unpack, classify, swap, align ----------------
   logic                 a_s, b_s, x_s, y_s, swap;
   logic [EXP_W-1:0]     a_e, b_e, x_e, y_e, x_ee, y_ee, diff;
   logic [MAN_W-1:0]     a_f, b_f, x_f, y_f;
   logic [M-1:0]         x_m, y_full, y_al;
   logic [2*M-1:0]       ext;
   logic [31:0]          sh_amt;
   logic                 a_nan, b_nan, a_inf, b_inf, nan_c, inf_c, inf_s_c;

   always_comb begin
      a_s = a[W-1];
      a_e = a[W-2:MAN_W];
      a_f = a[MAN_W-1:0];
      b_s = b[W-1] ^ op_sub;
      b_e = b[W-2:MAN_W];
      b_f = b[MAN_W-1:0];
      swap = {b_e, b_f} > {a_e, a_f};
      x_s = swap ? b_s : a_s;
      x_e = swap ? b_e : a_e;
      x_f = swap ? b_f : a_f;
      y_s = swap ? a_s : b_s;
      y_e = swap ? a_e : b_e;
      y_f = swap ? a_f : b_f;
      x_ee = (x_e == '0) ? EXP_W'(1) : x_e;
      y_ee = (y_e == '0) ? EXP_W'(1) : y_e;
      diff = x_ee - y_ee;
      x_m    = {(x_e != '0), x_f, 3'b000};
      y_full = {(y_e != '0), y_f, 3'b000};
      // Capping at M still pushes every bit into the low half, so sticky stays exact.
      sh_amt = (32'(diff) > 32'(M)) ? 32'(M) : 32'(diff);
      ext    = {y_full, {M{1'b0}}} >> sh_amt;
      y_al   = {ext[2*M-1:M+1], ext[M] | (|ext[M-1:0])};
      a_nan = (a_e == EXP_ONES) && (a_f != '0);
      b_nan = (b_e == EXP_ONES) && (b_f != '0);
      a_inf = (a_e == EXP_ONES) && (a_f == '0);
      b_inf = (b_e == EXP_ONES) && (b_f == '0);
      nan_c   = a_nan || b_nan || (a_inf && b_inf && (a_s != b_s));
      inf_c   = a_inf || b_inf;
      inf_s_c = a_inf ? a_s : b_s;
   end

   logic                 s1_valid, s1_xs, s1_ys, s1_nan, s1_inf, s1_inf_s;
   logic [EXP_W-1:0]     s1_e;
   logic [M-1:0]         s1_xm, s1_ym;

   always_ff @(posedge CLK) begin
      if (RST)
         s1_valid <= 1'b0;
      else if (advance)
         s1_valid <= in_valid;
   end

   always_ff @(posedge CLK) begin
      if (advance) begin
         s1_xm    <= x_m;
         s1_ym    <= y_al;
         s1_e     <= x_ee;
         s1_xs    <= x_s;
         s1_ys    <= y_s;
         s1_nan   <= nan_c;
         s1_inf   <= inf_c;
         s1_inf_s <= inf_s_c;
      end
   end

   // ---------------- stage 2: add or subtract magnitudes ----------------
   logic [M:0] sum_c;
   logic       sign_c;

   always_comb begin
      if (s1_xs != s1_ys)
         sum_c = {1'b0, s1_xm} - {1'b0, s1_ym};
      else
         sum_c = {1'b0, s1_xm} + {1'b0, s1_ym};
      sign_c = ((s1_xs != s1_ys) && (sum_c == '0)) ? 1'b0 : s1_xs;
   end

   logic                 s2_valid, s2_s, s2_nan, s2_inf, s2_inf_s;
   logic [EXP_W-1:0]     s2_e;
   logic [M:0]           s2_sum;

   always_ff @(posedge CLK) begin
      if (RST)
         s2_valid <= 1'b0;
      else if (advance)
         s2_valid <= s1_valid;
   end

   always_ff @(posedge CLK) begin
      if (advance) begin
         s2_sum   <= sum_c;
         s2_e     <= s1_e;
         s2_s     <= sign_c;
         s2_nan   <= s1_nan;
         s2_inf   <= s1_inf;
         s2_inf_s <= s1_inf_s;
      end
   end

   // ---------------- stage 3: normalise, round, pack ----------------
   logic [M-1:0]         n_m;
   logic [EXP_W+1:0]     n_e, f_e;
   logic [MAN_W+1:0]     mant;
   logic [MAN_W-1:0]     f_frac;
   logic                 g, rs, rnd, inexact;
   logic [W-1:0]         res_c;
   logic                 ovf_c, unf_c, inv_c;
   int                   lz, sh;

   always_comb begin
      lz = M;
      sh = 0;
      for (int i = 0; i < M; i++)
         if (s2_sum[i]) lz = M - 1 - i;
      if (s2_sum[M]) begin
         n_m = {s2_sum[M:2], s2_sum[1] | s2_sum[0]};
         n_e = {2'b00, s2_e} + (EXP_W+2)'(1);
      end else begin
         // Never normalise below exponent 1; what remains is a subnormal.
         sh  = (lz < int'(s2_e) - 1) ? lz : int'(s2_e) - 1;
         n_m = s2_sum[M-1:0] << sh;
         n_e = {2'b00, s2_e} - (EXP_W+2)'(sh);
      end
      g       = n_m[2];
      rs      = n_m[1] | n_m[0];
      rnd     = g & (rs | n_m[3]);
      inexact = g | rs;
      mant    = {1'b0, n_m[M-1:3]} + (MAN_W+2)'(rnd);
      if (mant[MAN_W+1]) begin
         f_e    = n_e + (EXP_W+2)'(1);
         f_frac = mant[MAN_W:1];
      end else begin
         f_e    = mant[MAN_W] ? n_e : '0;
         f_frac = mant[MAN_W-1:0];
      end
      ovf_c = 1'b0;
      unf_c = 1'b0;
      inv_c = 1'b0;
      if (s2_nan) begin
         res_c = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
         inv_c = 1'b1;
      end else if (s2_inf) begin
         res_c = {s2_inf_s, EXP_ONES, {MAN_W{1'b0}}};
      end else if (f_e >= {2'b00, EXP_ONES}) begin
         res_c = {s2_s, EXP_ONES, {MAN_W{1'b0}}};
         ovf_c = 1'b1;
      end else begin
         res_c = {s2_s, f_e[EXP_W-1:0], f_frac};
         unf_c = (f_e == '0) && inexact;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         out_valid <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         invalid   <= 1'b0;
      end else if (advance) begin
         out_valid <= s2_valid;
         overflow  <= s2_valid && ovf_c;
         underflow <= s2_valid && unf_c;
         invalid   <= s2_valid && inv_c;
         if (s2_valid)
            result <= res_c;
      end
   end
endmodule

// File: tb/tb_fpaddsub_pipe.sv
// tb/tb_fpaddsub_pipe.sv - scoreboard bench for fpaddsub_pipe: directed FP16 cases,
// backpressure, mid-stream reset and an FP32 parameterisation.
module tb_fpaddsub_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, op_sub, out_valid, out_ready;
   logic        overflow, underflow, invalid;
   logic [15:0] a, b, result;

   logic        in_valid32, in_ready32, out_valid32, ovf32, unf32, inv32;
   logic [31:0] a32, b32, result32;

   fpaddsub_pipe dut (
      .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .overflow(overflow), .underflow(underflow), .invalid(invalid)
   );

   fpaddsub_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
      .CLK(clk), .RST(rst), .in_valid(in_valid32), .in_ready(in_ready32),
      .a(a32), .b(b32), .op_sub(1'b0), .out_valid(out_valid32), .out_ready(1'b1),
      .result(result32), .overflow(ovf32), .underflow(unf32), .invalid(inv32)
   );

   int          total = 0;
   int          bad   = 0;
   int          npop  = 0;
   int          pop_mark;
   logic [18:0] sb[$];
   logic [18:0] head;

   logic [15:0] bp_a[8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                            16'h4500, 16'h4600, 16'h4700, 16'h4800};
   logic [15:0] bp_r[8] = '{16'h4000, 16'h4200, 16'h4400, 16'h4500,
                            16'h4600, 16'h4700, 16'h4800, 16'h4880};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [18:0] ex(input logic [15:0] r, input logic o, input logic u,
                                       input logic i);
      return {r, o, u, i};
   endfunction

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         total++;
         assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL extra_out: observed=%h expected=no output", result);
         end
         if (sb.size() > 0) begin
            npop++;
            check("out", {result, overflow, underflow, invalid}, sb.pop_front());
         end
      end
   end

   // Leaves in_valid high so consecutive calls stream back-to-back.
   task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                       input logic [18:0] e);
      int   n;
      logic acc;
      a = ta;
      b = tb;
      op_sub = ts;
      in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      check("accept", acc, 1'b1);
      if (acc) sb.push_back(e);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic lat_check(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                            input logic [18:0] e);
      send(ta, tb, ts, e);
      in_valid = 1'b0;
      @(negedge clk);
      check("lat_c1", out_valid, 1'b0);
      @(negedge clk);
      check("lat_c2", out_valid, 1'b0);
      @(negedge clk);
      check("lat_c3", out_valid, 1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b1;
      in_valid32 = 1'b0; a32 = '0; b32 = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_result", {result, overflow, underflow, invalid}, 19'h0);
      check("rst_out_valid32", out_valid32, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      lat_check(16'h3C00, 16'h3C00, 1'b0, ex(16'h4000, 0, 0, 0));
      send(16'h4200, 16'h3C00, 1'b1, ex(16'h4000, 0, 0, 0));
      send(16'h3C00, 16'h1000, 1'b0, ex(16'h3C00, 0, 0, 0));
      send(16'h3C01, 16'h1000, 1'b0, ex(16'h3C02, 0, 0, 0));
      send(16'h3C00, 16'h3C00, 1'b1, ex(16'h0000, 0, 0, 0));
      send(16'h3BFF, 16'h1000, 1'b0, ex(16'h3C00, 0, 0, 0));
      send(16'h3C00, 16'hC200, 1'b0, ex(16'hC000, 0, 0, 0));
      send(16'h7BFF, 16'h7BFF, 1'b0, ex(16'h7C00, 1, 0, 0));
      send(16'h7C00, 16'h7C00, 1'b1, ex(16'h7E00, 0, 0, 1));
      send(16'h7E01, 16'h3C00, 1'b0, ex(16'h7E00, 0, 0, 1));
      send(16'hFC00, 16'h3C00, 1'b0, ex(16'hFC00, 0, 0, 0));
      send(16'h0001, 16'h0001, 1'b0, ex(16'h0002, 0, 0, 0));
      send(16'h0400, 16'h0001, 1'b1, ex(16'h03FF, 0, 0, 0));
      send(16'h8000, 16'h8000, 1'b0, ex(16'h8000, 0, 0, 0));
      idle(6);
      check("drain_directed", sb.size(), 0);

      pop_mark = npop;
      fork
         begin
            for (int k = 0; k < 8; k++)
               send(bp_a[k], 16'h3C00, 1'b0, ex(bp_r[k], 0, 0, 0));
            in_valid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               head = sb[0];
               check("stall_in_ready", in_ready, 1'b0);
               check("stall_out_valid", out_valid, 1'b1);
               check("stall_hold", result, head[18:3]);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      idle(8);
      check("bp_drain", sb.size(), 0);
      check("bp_count", npop - pop_mark, 8);

      out_ready = 1'b0;
      send(16'h3C00, 16'h3C00, 1'b0, ex(16'h4000, 0, 0, 0));
      send(16'h4000, 16'h4000, 1'b0, ex(16'h4400, 0, 0, 0));
      send(16'h4400, 16'h4400, 1'b0, ex(16'h4800, 0, 0, 0));
      in_valid = 1'b0;
      rst = 1'b1;
      sb.delete();
      pop_mark = npop;
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_result", {result, overflow, underflow, invalid}, 19'h0);
      check("midrst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      lat_check(16'h4000, 16'h3C00, 1'b0, ex(16'h4200, 0, 0, 0));
      idle(8);
      check("midrst_count", npop - pop_mark, 1);

      a32 = 32'h3F800000;
      b32 = 32'h3F800000;
      in_valid32 = 1'b1;
      @(negedge clk);
      check("fp32_in_ready", in_ready32, 1'b1);
      @(posedge clk);
      #1 in_valid32 = 1'b0;
      @(negedge clk);
      check("fp32_c1", out_valid32, 1'b0);
      @(negedge clk);
      check("fp32_c2", out_valid32, 1'b0);
      @(negedge clk);
      check("fp32_c3", out_valid32, 1'b1);
      check("fp32_result", {result32, ovf32, unf32, inv32}, {32'h40000000, 3'b000});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
